// File: rtl/aes_sub_bytes_seq.sv
// aes_sub_bytes_seq
// Sequential forward SubBytes engine for the AES encrypt round. One 128-bit
// state is accepted, its bytes are replaced with the FIPS-197 forward S-box
// LOOKUP_BYTES at a time, and the result is returned.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. valid, once raised by the producer, stays high with stable
// data until that edge; ready may be asserted independently of valid.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active-low
//   in_valid   in_state is valid
//   in_ready   block can accept a state (only in IDLE)
//   in_state   input state, byte 0 = [127:120], byte 15 = [7:0]
//   out_valid  out_state holds a completed result
//   out_ready  downstream accepts out_state
//   out_state  substituted state, same byte ordering
//   busy       high while substituting or holding a result
//   check_err  (only with AES_SUB_BYTES_SELFCHECK_EN) inverse-S-box check
//              failed somewhere in the presented result
//
// Optional feature macro: AES_SUB_BYTES_SELFCHECK_EN
module aes_sub_bytes_seq #(
    parameter int LOOKUP_BYTES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
`ifdef AES_SUB_BYTES_SELFCHECK_EN
    ,
    output logic         check_err
`endif
);

    localparam int NG = 16 / LOOKUP_BYTES;
    localparam int CW = (NG > 1) ? $clog2(NG) : 1;
    localparam logic [CW-1:0] LAST_GRP = CW'(NG - 1);

    if (!(LOOKUP_BYTES == 1 || LOOKUP_BYTES == 2 || LOOKUP_BYTES == 4 ||
          LOOKUP_BYTES == 8 || LOOKUP_BYTES == 16)) begin : g_bad_param
        $error("aes_sub_bytes_seq: LOOKUP_BYTES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic [127:0]   work_q;
    logic [127:0]   work_d;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [127:0]   out_state_q;
    logic           busy_q;

    // GF(2^8) arithmetic with the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

`ifdef AES_SUB_BYTES_SELFCHECK_EN
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] b;
        b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    // Fault hook: normally zero; XORed into the first lookup of each group.
    logic [7:0] fault_mask;
    assign fault_mask = 8'h00;

    logic grp_err;
    logic err_q;
`endif

    // Substitute the current group; only the selected bytes change.
    logic [7:0] orig_b;
    logic [7:0] sub_b;
    int         byte_idx;

    always_comb begin
        work_d   = work_q;
        orig_b   = 8'h00;
        sub_b    = 8'h00;
        byte_idx = 0;
`ifdef AES_SUB_BYTES_SELFCHECK_EN
        grp_err  = 1'b0;
`endif
        for (int j = 0; j < LOOKUP_BYTES; j++) begin
            byte_idx = int'(cnt_q) * LOOKUP_BYTES + j;
            orig_b   = work_q[127 - 8*byte_idx -: 8];
            sub_b    = sbox(orig_b);
`ifdef AES_SUB_BYTES_SELFCHECK_EN
            if (j == 0) sub_b = sub_b ^ fault_mask;
            if (inv_sbox(sub_b) != orig_b) grp_err = 1'b1;
`endif
            work_d[127 - 8*byte_idx -: 8] = sub_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_state_q <= '0;
            busy_q      <= 1'b0;
`ifdef AES_SUB_BYTES_SELFCHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        work_q     <= in_state;
                        cnt_q      <= '0;
                        state_q    <= S_SUB;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef AES_SUB_BYTES_SELFCHECK_EN
                        err_q      <= 1'b0;
`endif
                    end
                end
                S_SUB: begin
                    work_q <= work_d;
`ifdef AES_SUB_BYTES_SELFCHECK_EN
                    if (grp_err) err_q <= 1'b1;
`endif
                    // Counter stops at the last group instead of wrapping.
                    if (cnt_q == LAST_GRP) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_state_q <= work_d;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign busy      = busy_q;
`ifdef AES_SUB_BYTES_SELFCHECK_EN
    assign check_err = out_valid_q & err_q;
`endif

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
module tb_aes_sub_bytes_seq;

  localparam logic [127:0] T1_IN    = 128'h000153ff_00000000_00000000_00000000;
  localparam logic [127:0] T1_OUT   = 128'h637ced16_63636363_63636363_63636363;
  localparam logic [127:0] FIPS_IN  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instance per legal LOOKUP_BYTES: index u -> L = 1 << u.
  logic [4:0]   in_valid;
  logic [4:0]   in_ready;
  logic [4:0]   out_valid;
  logic [4:0]   out_ready;
  logic [4:0]   busy;
  logic [127:0] in_state [5];
  logic [127:0] out_state [5];
`ifdef AES_SUB_BYTES_SELFCHECK_EN
  logic [4:0]   check_err;
`endif

  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes_sub_bytes_seq #(.LOOKUP_BYTES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
`ifdef AES_SUB_BYTES_SELFCHECK_EN
      ,
      .check_err (check_err[g])
`endif
    );
  end

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // From just after an accept edge: count edges until out_valid, check
  // latency and the result against the scoreboard.
  task automatic wait_out(input int u);
    int lat;
    logic [127:0] exp;
    lat = 0;
    while (!out_valid[u] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq($sformatf("latency_L%0d", 1 << u), 128'(lat), 128'(16 >> u));
    exp = exp_q.pop_front();
    check_eq($sformatf("out_state_L%0d", 1 << u), out_state[u], exp);
  endtask

  task automatic drive_in(input int u, input logic [127:0] data, input logic [127:0] exp);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready[u] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check_eq("in_ready_timeout", 128'(in_ready[u]), 128'd1);
    in_valid[u] = 1'b1;
    in_state[u] = data;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid[u] = 1'b0;
    wait_out(u);
  endtask

  // Hold out_ready low for 'stall' cycles, then hand the result off.
  task automatic release_out(input int u, input int stall, input logic [127:0] held);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq($sformatf("stall%0d_out_valid", i), 128'(out_valid[u]), 128'd1);
      check_eq($sformatf("stall%0d_out_state", i), out_state[u], held);
      check_eq($sformatf("stall%0d_in_ready", i), 128'(in_ready[u]), 128'd0);
    end
    @(negedge clk);
    out_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[u] = 1'b0;
    check_eq("post_hs_out_valid", 128'(out_valid[u]), 128'd0);
    check_eq("post_hs_in_ready", 128'(in_ready[u]), 128'd1);
    check_eq("post_hs_busy", 128'(busy[u]), 128'd0);
    check_eq("post_hs_out_state_held", out_state[u], held);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic seen;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    for (int u = 0; u < 5; u++) in_state[u] = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 128'(in_ready[0]), 128'd1);
    check_eq("rst_out_valid", 128'(out_valid[0]), 128'd0);
    check_eq("rst_out_state", out_state[0], 128'h0);
    check_eq("rst_busy", 128'(busy[0]), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-byte corner values, L=1
    drive_in(0, T1_IN, T1_OUT);
    check_eq("busy_in_done", 128'(busy[0]), 128'd1);
    release_out(0, 0, T1_OUT);

    // FIPS-197 round-1 vector for every legal L
    for (int u = 0; u < 5; u++) begin
      drive_in(u, FIPS_IN, FIPS_OUT);
      release_out(u, 0, FIPS_OUT);
    end

    // Backpressure with a competing input held during DONE
    drive_in(0, FIPS_IN, FIPS_OUT);
    in_valid[0] = 1'b1;
    in_state[0] = T1_IN;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq($sformatf("bp%0d_out_valid", i), 128'(out_valid[0]), 128'd1);
      check_eq($sformatf("bp%0d_out_state", i), out_state[0], FIPS_OUT);
      check_eq($sformatf("bp%0d_in_ready", i), 128'(in_ready[0]), 128'd0);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    check_eq("bp_hs_out_valid", 128'(out_valid[0]), 128'd0);
    check_eq("bp_hs_in_ready", 128'(in_ready[0]), 128'd1);
    exp_q.push_back(T1_OUT);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    check_eq("bp_accept_in_ready", 128'(in_ready[0]), 128'd0);
    wait_out(0);
    release_out(0, 0, T1_OUT);

    // Reset in SUB cycle 7 (L=1)
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_state[0] = FIPS_IN;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_out_valid", 128'(out_valid[0]), 128'd0);
    check_eq("midrst_out_state", out_state[0], 128'h0);
    check_eq("midrst_busy", 128'(busy[0]), 128'd0);
    check_eq("midrst_in_ready", 128'(in_ready[0]), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | out_valid[0];
    end
    check_eq("midrst_no_out_valid", 128'(seen), 128'd0);
    drive_in(0, FIPS_IN, FIPS_OUT);
    release_out(0, 0, FIPS_OUT);

`ifdef AES_SUB_BYTES_SELFCHECK_EN
    // Bit-flip in the lookup path must raise check_err with the result
    force g_dut[0].u_dut.fault_mask = 8'h01;
    drive_in(0, FIPS_IN, FIPS_OUT ^ {16{8'h01}});
    check_eq("selfchk_err_set", 128'(check_err[0]), 128'd1);
    release out_ready[0];
    release g_dut[0].u_dut.fault_mask;
    release_out(0, 0, FIPS_OUT ^ {16{8'h01}});
    check_eq("selfchk_err_idle", 128'(check_err[0]), 128'd0);
    drive_in(0, FIPS_IN, FIPS_OUT);
    check_eq("selfchk_err_clean", 128'(check_err[0]), 128'd0);
    release_out(0, 0, FIPS_OUT);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_sub_bytes_seq.md
Name: aes_sub_bytes_seq

Overview:
- Sequential forward SubBytes engine for the AES encryption datapath; the encrypt-side counterpart of the decryption-side inverse S-box lookup.
- Accepts one 128-bit AES state through a valid/ready handshake.
- Substitutes every byte with the FIPS-197 forward S-box, LOOKUP_BYTES bytes per clock.
- Returns the result through a valid/ready handshake. Sits between AddRoundKey and ShiftRows in the encrypt round pipeline.

Parameters:
- LOOKUP_BYTES, 1, bytes substituted per cycle. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration-time error.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  in_state is valid
- in_ready  output  1  block can accept a state; high only in IDLE
- in_state  input  128  state to substitute; byte 0 = [127:120], byte 15 = [7:0]
- out_valid  output  1  out_state holds a completed result
- out_ready  input  1  downstream accepts out_state
- out_state  output  128  substituted state, same byte ordering as in_state
- busy  output  1  high in SUB or DONE

Behaviour:
- One clock domain. Reset is synchronous, active-low: sampled on clk rising edge while rst_n=0.
- Reset values:
  - state = IDLE, group counter = 0.
  - out_valid = 0, out_state = 128'h0, busy = 0.
  - in_ready = 1 from the first edge after rst_n=0 is sampled.
- FSM states: IDLE, SUB, DONE.
- IDLE:
  - in_ready = 1.
  - If in_valid=1, load in_state into the working register, clear the counter, go to SUB.
- SUB:
  - Each cycle, bytes [cnt*LOOKUP_BYTES .. cnt*LOOKUP_BYTES+LOOKUP_BYTES-1] of the working register are replaced by S(byte); cnt increments.
  - When the group at cnt = 16/LOOKUP_BYTES - 1 is written, go to DONE.
  - Lookup is combinational. Each group is written on the edge that ends its SUB cycle.
- DONE:
  - out_valid = 1 and out_state = working register, held stable until accepted.
  - When out_valid and out_ready are both high, go to IDLE. out_valid drops on that edge.
- Latency: out_valid rises exactly 16/LOOKUP_BYTES cycles after the accept edge (L=1: 16; L=16: 1).
- Throughput: one state per 16/LOOKUP_BYTES + 2 cycles with out_ready tied high. No accept in the same cycle as the output handshake; in_ready returns the cycle after.
- out_state is not updated outside the DONE transition. It holds the last result after return to IDLE.
- in_valid while not in IDLE is ignored (in_ready=0). in_state is not sampled.
- out_ready while out_valid=0 has no effect.
- Reset asserted mid-SUB or in DONE abandons the operation:
  - All outputs return to reset values on that edge.
  - No partial result is ever presented.
- Counter width is ceil(log2(16/LOOKUP_BYTES)), minimum 1 bit. It never wraps past the final group.

Optional Feature:
- Macro: AES_SUB_BYTES_SELFCHECK_EN
- When defined:
  - Adds output port check_err (1 bit, reset 0).
  - Each substituted byte is passed back through an inverse S-box and compared with the original byte.
  - Any mismatch in any group sets a sticky error flag. check_err presents that flag while out_valid=1.
  - The flag clears on the next accepted input or on reset. check_err = 0 whenever out_valid=0.
- When undefined: no check_err port, no inverse lookup logic. Behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, release -> in_ready=1, out_valid=0, out_state=0, busy=0.
- Single bytes, L=1:
  - Input 0x00,0x01,0x53,0xff in bytes 0..3, rest 0x00.
  - Expect out_state=0x637ced16 followed by twelve 0x63 bytes.
  - out_valid rises 16 cycles after accept.
- FIPS-197 round-1 vector, all legal L values:
  - in = 193de3bea0f4e22b9ac68d2ae9f84808 -> out = d42711aee0bf98f1b8b45de51e415230.
  - Latency = 16/L cycles for each L.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_state stable, in_ready=0.
  - Raise out_ready -> IDLE next cycle.
  - A new in_valid is accepted only from that cycle.
- Reset mid-op:
  - Assert rst_n=0 at SUB cycle 7 (L=1) -> out_valid never rises, outputs return to reset values.
  - A following clean transaction produces the correct result.
- Self-check, with the macro defined:
  - Force one S-box output bit flip via a bench hook -> check_err=1 with out_valid.
  - The next clean transaction -> check_err=0.
